// File: rtl/vsrc_sweep_ctrl.sv
// vsrc_sweep_ctrl: linear sweep sequencer for a code-driven DC voltage source.
// It steps src_code from cfg_start by cfg_step for cfg_points points, waits
// cfg_dwell cycles at each point, then hands the point to a measurement block
// through the smp_req/smp_ack handshake.
//
// Optional build macro VSRC_SWEEP_BIDIR_EN: after the last forward point the
// sweep retraces back to index 0 with -step (turnaround not repeated), and an
// extra output 'dir' (1 = reverse) is present.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, abort            sweep start pulse, sweep abort level
//   cfg_start, cfg_step     first code, signed increment (latched at start)
//   cfg_points, cfg_dwell   point count, settle cycles per point (latched)
//   src_code, src_en        code and enable to the source/DAC model
//   smp_req, smp_ack        measurement handshake
//   idx                     current point index
//   busy, done, sat         not-idle, completion pulse, sticky clamp flag
//   dir                     sweep direction (VSRC_SWEEP_BIDIR_EN only)
module vsrc_sweep_ctrl #(
    parameter int unsigned CODE_W  = 12,
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [CODE_W-1:0]  cfg_start,
    input  logic [CODE_W-1:0]  cfg_step,
    input  logic [CNT_W-1:0]   cfg_points,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic [CODE_W-1:0]  src_code,
    output logic               src_en,
    output logic               smp_req,
    input  logic               smp_ack,
    output logic [CNT_W-1:0]   idx,
    output logic               busy,
    output logic               done,
    output logic               sat
`ifdef VSRC_SWEEP_BIDIR_EN
    ,
    output logic               dir
`endif
);

    // Two guard bits so any code plus or minus any step is represented exactly.
    localparam int unsigned SUM_W = CODE_W + 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CODE_W-1:0]  step_q, step_nxt;
    logic [CNT_W-1:0]   points_q, points_nxt;
    logic [DWELL_W-1:0] dwell_q, dwell_nxt;
    logic [DWELL_W-1:0] timer, timer_nxt;
    logic [CODE_W-1:0]  code_nxt;
    logic [CNT_W-1:0]   idx_nxt;
    logic               sat_nxt;
    logic               rev, rev_nxt;

    logic [CNT_W-1:0]   last_idx;
    logic               next_rev;
    logic               sweep_end;
    logic [SUM_W-1:0]   step_ext;
    logic [SUM_W-1:0]   code_ext;
    logic [SUM_W-1:0]   sum;
    logic [CODE_W-1:0]  code_step;
    logic               clamp;
    logic [CNT_W-1:0]   idx_step;

    assign last_idx = points_q - CNT_W'(1);

`ifdef VSRC_SWEEP_BIDIR_EN
    // Next point runs in reverse once the forward leg's last point is acked.
    assign next_rev  = rev || (!rev && (idx == last_idx));
    assign sweep_end = (idx == '0) && next_rev;
    assign dir       = rev;
`else
    assign next_rev  = 1'b0;
    assign sweep_end = (idx == last_idx);
`endif

    // Next code: wide signed sum, then clamp into the unsigned code range.
    always_comb begin
        step_ext  = {{2{step_q[CODE_W-1]}}, step_q};
        code_ext  = {2'b00, src_code};
        sum       = next_rev ? (code_ext - step_ext) : (code_ext + step_ext);
        clamp     = 1'b0;
        code_step = sum[CODE_W-1:0];
        if (sum[SUM_W-1]) begin
            code_step = '0;
            clamp     = 1'b1;
        end else if (sum[CODE_W]) begin
            code_step = '1;
            clamp     = 1'b1;
        end
        idx_step = next_rev ? (idx - CNT_W'(1)) : (idx + CNT_W'(1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort wins over ack and start.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && !abort)
                    state_nxt = (cfg_points == '0) ? S_DONE : S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)              state_nxt = S_IDLE;
                else if (timer == '0)   state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort)              state_nxt = S_IDLE;
                else if (smp_ack)       state_nxt = sweep_end ? S_DONE : S_SETTLE;
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output/datapath next values; everything holds unless a transition acts.
    always_comb begin
        code_nxt   = src_code;
        idx_nxt    = idx;
        sat_nxt    = sat;
        timer_nxt  = timer;
        step_nxt   = step_q;
        points_nxt = points_q;
        dwell_nxt  = dwell_q;
        rev_nxt    = rev;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    step_nxt   = cfg_step;
                    points_nxt = cfg_points;
                    dwell_nxt  = cfg_dwell;
                    timer_nxt  = cfg_dwell;
                    idx_nxt    = '0;
                    sat_nxt    = 1'b0;
                    rev_nxt    = 1'b0;
                    if (cfg_points != '0) code_nxt = cfg_start;
                end
            end
            S_SETTLE: begin
                if (timer != '0) timer_nxt = timer - DWELL_W'(1);
            end
            S_SAMPLE: begin
                if (!abort && smp_ack && !sweep_end) begin
                    idx_nxt   = idx_step;
                    code_nxt  = code_step;
                    sat_nxt   = sat | clamp;
                    timer_nxt = dwell_q;
                    rev_nxt   = next_rev;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers; handshake/status flags follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_code <= '0;
            src_en   <= 1'b0;
            smp_req  <= 1'b0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sat      <= 1'b0;
            step_q   <= '0;
            points_q <= '0;
            dwell_q  <= '0;
            timer    <= '0;
            rev      <= 1'b0;
        end else begin
            src_code <= code_nxt;
            src_en   <= (state_nxt == S_SETTLE) || (state_nxt == S_SAMPLE);
            smp_req  <= (state_nxt == S_SAMPLE);
            idx      <= idx_nxt;
            busy     <= (state_nxt != S_IDLE);
            done     <= (state_nxt == S_DONE);
            sat      <= sat_nxt;
            step_q   <= step_nxt;
            points_q <= points_nxt;
            dwell_q  <= dwell_nxt;
            timer    <= timer_nxt;
            rev      <= rev_nxt;
        end
    end

endmodule

// File: tb/tb_vsrc_sweep_ctrl.sv
// Self-checking bench for vsrc_sweep_ctrl: table of directed sweeps, hand
// sequences for reset/abort/zero-points, and randomized sweeps checked against
// a list-of-codes reference model. Honors VSRC_SWEEP_BIDIR_EN.
module tb_vsrc_sweep_ctrl;

    localparam int unsigned CODE_W  = 12;
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned DWELL_W = 16;
    localparam int CODE_MAX = 4095;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               smp_ack = 1'b0;
    logic [CODE_W-1:0]  cfg_start = '0;
    logic [CODE_W-1:0]  cfg_step = '0;
    logic [CNT_W-1:0]   cfg_points = '0;
    logic [DWELL_W-1:0] cfg_dwell = '0;
    logic [CODE_W-1:0]  src_code;
    logic               src_en;
    logic               smp_req;
    logic [CNT_W-1:0]   idx;
    logic               busy;
    logic               done;
    logic               sat;
`ifdef VSRC_SWEEP_BIDIR_EN
    logic               dir;
`endif

    vsrc_sweep_ctrl #(.CODE_W(CODE_W), .CNT_W(CNT_W), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_start(cfg_start), .cfg_step(cfg_step), .cfg_points(cfg_points),
        .cfg_dwell(cfg_dwell), .src_code(src_code), .src_en(src_en),
        .smp_req(smp_req), .smp_ack(smp_ack), .idx(idx), .busy(busy),
        .done(done), .sat(sat)
`ifdef VSRC_SWEEP_BIDIR_EN
        , .dir(dir)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int st;
        int stp;
        int pts;
        int dwl;
        int dly;
        int n_exp;
        int last_exp;
        int sat_exp;
    } vec_t;

    vec_t vecs[7];

    // Reference model: expected per-sample code, index, sticky sat, direction.
    int exp_code[$];
    int exp_idx[$];
    int exp_sat[$];
    int exp_dir[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void build_model(input int st, input int stp, input int pts);
        int c;
        int s;
        exp_code.delete(); exp_idx.delete(); exp_sat.delete(); exp_dir.delete();
        c = st;
        s = 0;
        for (int i = 0; i < pts; i++) begin
            if (i > 0) begin
                c = c + stp;
                if (c < 0) begin c = 0; s = 1; end
                else if (c > CODE_MAX) begin c = CODE_MAX; s = 1; end
            end
            exp_code.push_back(c); exp_idx.push_back(i);
            exp_sat.push_back(s);  exp_dir.push_back(0);
        end
`ifdef VSRC_SWEEP_BIDIR_EN
        for (int i = pts - 2; i >= 0; i--) begin
            c = c - stp;
            if (c < 0) begin c = 0; s = 1; end
            else if (c > CODE_MAX) begin c = CODE_MAX; s = 1; end
            exp_code.push_back(c); exp_idx.push_back(i);
            exp_sat.push_back(s);  exp_dir.push_back(1);
        end
`endif
    endfunction

    // Run one full sweep (pts >= 1), checking every sample against the model.
    task automatic run_sweep(input int st, input int stp, input int pts, input int dwl,
                             input int dly_min, input int dly_max, output int n_samp);
        int cnt;
        int dly;
        int stable;
        int done_seen;
        cfg_start  = CODE_W'(st);
        cfg_step   = CODE_W'(stp);
        cfg_points = CNT_W'(pts);
        cfg_dwell  = DWELL_W'(dwl);
        build_model(st, stp, pts);
        start = 1'b1;
        tick();
        start = 1'b0;
        // Configuration must be latched; scramble it for the rest of the sweep.
        cfg_start  = CODE_W'($urandom);
        cfg_step   = CODE_W'($urandom);
        cfg_points = CNT_W'($urandom);
        cfg_dwell  = DWELL_W'($urandom_range(0, 7));
        n_samp = 0;
        done_seen = 0;
        for (int k = 0; k < exp_code.size(); k++) begin
            cnt = 0;
            while (!smp_req && cnt < dwl + 10) begin
                smp_ack = 1'($urandom_range(0, 1));  // ignored outside SAMPLE
                tick();
                cnt++;
                if (done) done_seen++;
            end
            smp_ack = 1'b0;
            check("req_latency", 32'(cnt), 32'(dwl + 1));
            check("code", 32'(src_code), 32'(exp_code[k]));
            check("idx", 32'(idx), 32'(exp_idx[k]));
            check("sat", 32'(sat), 32'(exp_sat[k]));
            check("src_en", 32'(src_en), 32'd1);
            check("busy", 32'(busy), 32'd1);
`ifdef VSRC_SWEEP_BIDIR_EN
            check("dir", 32'(dir), 32'(exp_dir[k]));
`endif
            dly = int'($urandom_range(dly_min, dly_max));
            stable = 0;
            for (int j = 0; j < dly; j++) begin
                start = 1'($urandom_range(0, 1));    // ignored while busy
                tick();
                if (smp_req && src_code == CODE_W'(exp_code[k]) && idx == CNT_W'(exp_idx[k]))
                    stable++;
            end
            start = 1'b0;
            if (dly > 0) check("ack_hold", 32'(stable), 32'(dly));
            smp_ack = 1'b1;
            tick();
            smp_ack = 1'b0;
            n_samp++;
            check("req_drop", 32'(smp_req), 32'd0);
        end
        check("no_early_done", 32'(done_seen), 32'd0);
        check("done_pulse", 32'(done), 32'd1);
        tick();
        check("done_single", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_src_en", 32'(src_en), 32'd0);
        check("code_held", 32'(src_code), 32'(exp_code[exp_code.size() - 1]));
        check("idx_held", 32'(idx), 32'(exp_idx[exp_idx.size() - 1]));
    endtask

    initial begin
        int ns;
        int cnt;
        int stp;
        int pts;

        // st, stp, pts, dwl, ack delay, samples, last code, sat
`ifdef VSRC_SWEEP_BIDIR_EN
        vecs[0] = '{100,    10, 4, 3,  1, 7,  100, 0};
        vecs[1] = '{77,      3, 1, 0,  0, 1,   77, 0};
        vecs[2] = '{4090,    4, 3, 2,  0, 5, 4087, 1};
        vecs[3] = '{5,      -8, 3, 1,  2, 5,   16, 1};
        vecs[4] = '{0,       5, 3, 2, 20, 5,    0, 0};
        vecs[5] = '{2000, -2048, 2, 0,  0, 3, 2048, 1};
        vecs[6] = '{4095, 2047, 2, 1,  0, 3, 2048, 1};
`else
        vecs[0] = '{100,    10, 4, 3,  1, 4,  130, 0};
        vecs[1] = '{77,      3, 1, 0,  0, 1,   77, 0};
        vecs[2] = '{4090,    4, 3, 2,  0, 3, 4095, 1};
        vecs[3] = '{5,      -8, 3, 1,  2, 3,    0, 1};
        vecs[4] = '{0,       5, 3, 2, 20, 3,   10, 0};
        vecs[5] = '{2000, -2048, 2, 0,  0, 2,    0, 1};
        vecs[6] = '{4095, 2047, 2, 1,  0, 2, 4095, 1};
`endif

        // Reset state.
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_code", 32'(src_code), 32'd0);
        check("rst_flags", {26'd0, src_en, smp_req, busy, done, sat, 1'b0}, 32'd0);
        check("rst_idx", 32'(idx), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed sweeps from the table.
        for (int v = 0; v < 7; v++) begin
            run_sweep(vecs[v].st, vecs[v].stp, vecs[v].pts, vecs[v].dwl,
                      vecs[v].dly, vecs[v].dly, ns);
            check("tbl_samples", 32'(ns), 32'(vecs[v].n_exp));
            check("tbl_last_code", 32'(src_code), 32'(vecs[v].last_exp));
            check("tbl_sat", 32'(sat), 32'(vecs[v].sat_exp));
            repeat (2) tick();
        end

        // Zero points: straight to a done pulse with the source off.
        cfg_start = 12'd300; cfg_step = 12'd1; cfg_points = '0; cfg_dwell = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done", 32'(done), 32'd1);
        check("zero_src_en", 32'(src_en), 32'd0);
        check("zero_req", 32'(smp_req), 32'd0);
        tick();
        check("zero_done_end", 32'(done), 32'd0);
        check("zero_busy_end", 32'(busy), 32'd0);

        // Abort in SETTLE of the second point, with a concurrent start.
        cfg_start = 12'd200; cfg_step = 12'd3; cfg_points = 10'd4; cfg_dwell = 16'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        while (!smp_req && cnt < 20) begin tick(); cnt++; end
        check("abort_first_req", 32'(smp_req), 32'd1);
        smp_ack = 1'b1;
        tick();
        smp_ack = 1'b0;
        tick();
        check("abort_pre_src_en", 32'(src_en), 32'd1);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_src_en", 32'(src_en), 32'd0);
        check("abort_req", 32'(smp_req), 32'd0);
        check("abort_code_held", 32'(src_code), 32'd203);
        check("abort_idx_held", 32'(idx), 32'd1);
        cnt = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (done || busy) cnt++;
        end
        check("abort_no_done", 32'(cnt), 32'd0);
        run_sweep(50, 7, 3, 1, 0, 1, ns);
        check("post_abort_samples", 32'(ns), 32'(exp_code.size()));

        // Asynchronous reset while a sample is pending with sat set.
        cfg_start = 12'd4095; cfg_step = 12'd1; cfg_points = 10'd3; cfg_dwell = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        smp_ack = 1'b1;
        tick();
        smp_ack = 1'b0;
        cnt = 0;
        while (!smp_req && cnt < 10) begin tick(); cnt++; end
        check("prereset_sat", 32'(sat), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_code", 32'(src_code), 32'd0);
        check("arst_flags", {26'd0, src_en, smp_req, busy, done, sat, 1'b0}, 32'd0);
        check("arst_idx", 32'(idx), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);

        // Randomized sweeps against the reference model.
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 1) == 1) stp = int'($urandom_range(0, 40)) - 20;
            else                           stp = int'($urandom_range(0, 4095)) - 2048;
            pts = int'($urandom_range(1, 6));
            run_sweep(int'($urandom_range(0, 4095)), stp, pts,
                      int'($urandom_range(0, 4)), 0, 3, ns);
            check("rnd_samples", 32'(ns), 32'(exp_code.size()));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
